// File: rtl/gate_vec_pkg.sv
// Shared encodings and truth-table constants for the gate vector checker.
package gate_vec_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    // Saturating increment for the mismatch counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle-window timer: counts WAIT cycles and flags the last one.
module gate_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] wcnt_q;
    logic [CW-1:0] wcnt_d;

    // Expire on the final settle cycle; counter holds there until reloaded.
    always_comb begin
        expire_c = en && (wcnt_q == LAST);
        wcnt_d   = wcnt_q;
        if (load) begin
            wcnt_d = '0;
        end else if (en && !expire_c) begin
            wcnt_d = wcnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps all input vectors onto a gate, samples its output after a settle
// window and compares against a truth table; reports errors and first failure.
module gate_vector_checker
    import gate_vec_pkg::*;
#(
    parameter int unsigned              N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]     EXPECT = (2**N_IN)'(TT_NAND),
    parameter int unsigned              SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              y_dut,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   fail_vec,
    output logic              fail_vld
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic              fail_vld_q, fail_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              timer_load_c;
    logic              timer_en_c;
    logic              settle_expire_c;
    logic              mismatch_c;

    assign timer_en_c = (state_q == ST_WAIT);

    gate_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_c),
        .en       (timer_en_c),
        .expire_c (settle_expire_c)
    );

    // Case equality so an undriven or unknown gate output counts as a failure.
    assign mismatch_c = (y_dut !== EXPECT[stim_q]);

    // Next-state, vector counter, comparator and error capture.
    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_vld_d   = fail_vld_q;
        timer_load_c = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_WAIT;
                    stim_d       = '0;
                    err_cnt_d    = '0;
                    fail_vld_d   = 1'b0;
                    timer_load_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (settle_expire_c) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (!fail_vld_q) begin
                        fail_vec_d = stim_q;
                        fail_vld_d = 1'b1;
                    end
                end
                if (stim_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    state_d      = ST_WAIT;
                    stim_d       = stim_q + N_IN'(1);
                    timer_load_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stim_q     <= '0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
            fail_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stim_q     <= stim_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            fail_vld_q <= fail_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign stim     = stim_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;
    assign fail_vld = fail_vld_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: cycle-level reference model for a 2-input
// instance plus a wide saturating instance.
module tb_gate_vector_checker;
    import gate_vec_pkg::*;

    localparam int NV    = 4;
    localparam int S     = 2;
    localparam int SWEEP = NV * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;

    logic [1:0] stim_a, fail_vec_a;
    logic       y_a, busy_a, done_a, pass_a, fail_vld_a;
    logic [7:0] err_a;

    logic [7:0] stim_b, fail_vec_b;
    logic       y_b, busy_b, done_b, pass_b, fail_vld_b;
    logic [7:0] err_b;

    int         mode = 0;
    logic [3:0] rnd_tt = 4'b0000;
    logic [3:0] exp_tt = TT_NAND;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Gate stand-ins: 0 real NAND, 1 stuck-at-0, 2 AND (inverted NAND), 3 random table.
    function automatic logic gate_y(input int m, input logic [3:0] tt, input logic [1:0] k);
        case (m)
            0:       return ~(k[1] & k[0]);
            1:       return 1'b0;
            2:       return k[1] & k[0];
            default: return tt[k];
        endcase
    endfunction

    assign y_a = gate_y(mode, rnd_tt, stim_a);
    assign y_b = 1'b0;

    gate_vector_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .y_dut(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_vec(fail_vec_a), .fail_vld(fail_vld_a)
    );

    gate_vector_checker #(.N_IN(8), .EXPECT({256{1'b1}}), .SETTLE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .y_dut(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_vec(fail_vec_b), .fail_vld(fail_vld_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 sweeping (m_c edges since start), 2 finished.
    int m_phase = 0;
    int m_c = 0;
    int m_dc = 0;
    int m_err = 0;
    int m_fvec = 0;
    bit m_fvld = 1'b0;

    always @(posedge clk) begin : model_and_compare
        int k;
        int e_stim;
        bit e_done;
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_c = 0; m_err = 0; m_fvld = 1'b0; m_fvec = 0;
        end else if (m_phase != 1 && start_a) begin
            m_phase = 1; m_c = 0; m_err = 0; m_fvld = 1'b0;
        end else if (m_phase == 1) begin
            m_c++;
            if (m_c >= S + 1 && (m_c - (S + 1)) % (S + 1) == 0) begin
                k = (m_c - (S + 1)) / (S + 1);
                if (gate_y(mode, rnd_tt, 2'(k)) != exp_tt[k]) begin
                    if (m_err < 255) m_err++;
                    if (!m_fvld) begin
                        m_fvld = 1'b1;
                        m_fvec = k;
                    end
                end
            end
            if (m_c == SWEEP) begin
                m_phase = 2;
                m_dc = 0;
            end
        end else if (m_phase == 2) begin
            m_dc++;
        end

        #1;
        if (m_phase == 1)      e_stim = (m_c / (S + 1) > NV - 1) ? NV - 1 : m_c / (S + 1);
        else if (m_phase == 2) e_stim = NV - 1;
        else                   e_stim = 0;
        e_done = (m_phase == 2) && (m_dc >= 1);
        check("busy",     32'(busy_a),     32'(m_phase == 1));
        check("stim",     32'(stim_a),     32'(e_stim));
        check("done",     32'(done_a),     32'(e_done));
        check("pass",     32'(pass_a),     32'(e_done && m_err == 0));
        check("err_cnt",  32'(err_a),      32'(m_err));
        check("fail_vld", 32'(fail_vld_a), 32'(m_fvld));
        if (m_fvld) check("fail_vec", 32'(fail_vec_a), 32'(m_fvec));
    end

    task automatic check_all_zero_a(input string tag);
        check({tag, "_busy"},     32'(busy_a),     32'd0);
        check({tag, "_done"},     32'(done_a),     32'd0);
        check({tag, "_pass"},     32'(pass_a),     32'd0);
        check({tag, "_err"},      32'(err_a),      32'd0);
        check({tag, "_stim"},     32'(stim_a),     32'd0);
        check({tag, "_fail_vld"}, 32'(fail_vld_a), 32'd0);
        check({tag, "_fail_vec"}, 32'(fail_vec_a), 32'd0);
    endtask

    // One sweep on instance A; optional extra starts at relative edges 3 and 7,
    // optional reset asserted just before relative edge abort_at.
    task automatic do_sweep(input bit extra, input int abort_at, output int done_edge);
        int e0;
        int rel;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        e0 = cyc;
        done_edge = -1;
        while (!done_a && (cyc - e0) < 100) begin
            rel = cyc - e0 + 1;
            start_a = extra && (rel == 3 || rel == 7);
            if (abort_at > 0 && rel == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero_a("abort");
                @(negedge clk) rst_n = 1'b1;
                start_a = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        check("done_timeout", 32'(done_a), 32'd1);
        done_edge = cyc - e0;
    endtask

    initial begin : driver
        int de;
        int e0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero_a("reset");
        check("reset_b_err", 32'(err_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Real NAND: clean pass, done after edge 13.
        mode = 0;
        do_sweep(1'b0, 0, de);
        check("nand_done_edge", 32'(de), 32'd13);
        check("nand_err", 32'(err_a), 32'd0);
        check("nand_pass", 32'(pass_a), 32'd1);
        check("nand_fvld", 32'(fail_vld_a), 32'd0);

        // Output stuck at 0: vectors 0..2 fail.
        mode = 1;
        do_sweep(1'b0, 0, de);
        check("stuck0_err", 32'(err_a), 32'd3);
        check("stuck0_fvec", 32'(fail_vec_a), 32'd0);
        check("stuck0_fvld", 32'(fail_vld_a), 32'd1);
        check("stuck0_pass", 32'(pass_a), 32'd0);

        // Fully inverted gate: every vector fails.
        mode = 2;
        do_sweep(1'b0, 0, de);
        check("inv_err", 32'(err_a), 32'd4);
        check("inv_fvec", 32'(fail_vec_a), 32'd0);

        // Start pulses while busy are ignored.
        mode = 0;
        do_sweep(1'b1, 0, de);
        check("restart_done_edge", 32'(de), 32'd13);
        repeat (3) @(negedge clk);
        check("restart_single", 32'(busy_a), 32'd0);

        // Reset during the settle window of vector 2, then a clean sweep.
        do_sweep(1'b0, 7, de);
        do_sweep(1'b0, 0, de);
        check("post_abort_pass", 32'(pass_a), 32'd1);
        check("post_abort_edge", 32'(de), 32'd13);

        // Randomised gates, idle gaps, stray starts and occasional aborts.
        for (int it = 0; it < 24; it++) begin
            mode = 3;
            rnd_tt = 4'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_sweep(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, SWEEP)) : 0, de);
        end

        // Wide instance: 256 mismatches saturate the counter.
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        e0 = cyc;
        while (!done_b && (cyc - e0) < 700) @(negedge clk);
        check("sat_done_timeout", 32'(done_b), 32'd1);
        check("sat_done_edge", 32'(cyc - e0), 32'd513);
        check("sat_err", 32'(err_b), 32'd255);
        check("sat_pass", 32'(pass_b), 32'd0);
        check("sat_fvec", 32'(fail_vec_b), 32'd0);
        check("sat_fvld", 32'(fail_vld_b), 32'd1);
        check("sat_stim", 32'(stim_b), 32'd255);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
